// File: rtl/switch_port_arbiter.sv
// rtl/switch_port_arbiter.sv - round-robin packet mover from three input RAMs to three destination FIFOs
module switch_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3*ADDR_W-1:0]   wr_ptr,
    input  logic [3*DATA_W-1:0]   ram_q,
    output logic [3*ADDR_W-1:0]   ram_rd_add,
    output logic [2:0]            ram_rden,
    input  logic [2:0]            fifo_full,
    output logic [DATA_W-1:0]     fifo_data,
    output logic [2:0]            fifo_wr,
    output logic [2:0]            grant,
    output logic                  busy,
    output logic [7:0]            drop_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HRD, S_HDEC, S_HWR, S_PRD, S_PWR, S_DROP
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rd_ptr [3];
    logic [1:0]          r_g;
    logic [1:0]          r_last;
    logic [2:0]          r_grant;
    logic [DATA_W-1:0]   r_header;
    logic [1:0]          r_dest;
    logic [3:0]          r_cnt;
    logic [7:0]          r_drop;

    logic [2:0]          w_pend;
    logic [DATA_W-1:0]   w_q_arr [3];
    logic [DATA_W-1:0]   w_q;
    logic                w_cur_pend;
    logic                w_full;
    logic [2:0]          w_dest_oh;
    logic [1:0]          w_c0, w_c1, w_c2;
    logic [1:0]          w_next;
    logic                w_found;
    logic [2:0]          w_rden;
    logic [2:0]          w_wr;
    logic [DATA_W-1:0]   w_data;

    for (genvar i = 0; i < 3; i++) begin : g_port
        assign w_pend[i] = (r_rd_ptr[i] != wr_ptr[ADDR_W*i +: ADDR_W]);
        assign w_q_arr[i] = ram_q[DATA_W*i +: DATA_W];
        assign ram_rd_add[ADDR_W*i +: ADDR_W] = r_rd_ptr[i];
    end

    assign w_q        = w_q_arr[r_g];
    assign w_cur_pend = w_pend[r_g];
    assign w_full     = fifo_full[r_dest - 2'd1];
    assign w_dest_oh  = 3'b001 << (r_dest - 2'd1);

    // Cyclic search order starting just after the last granted port
    assign w_c0 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    assign w_c1 = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
    assign w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    assign w_found = |w_pend;

    always_comb begin
        w_next = w_c2;
        if (w_pend[w_c1]) w_next = w_c1;
        if (w_pend[w_c0]) w_next = w_c0;
    end

    // Strobes depend on the live full flag, so they are decoded from the registered state
    always_comb begin
        w_rden = '0;
        w_wr   = '0;
        w_data = '0;
        case (r_state)
            S_HRD: w_rden = r_grant;
            S_HWR: begin
                if (!w_full) begin
                    w_wr   = w_dest_oh;
                    w_data = r_header;
                end
            end
            S_PRD: begin
                if (r_cnt != 4'd0 && w_cur_pend && !w_full) w_rden = r_grant;
            end
            S_PWR: begin
                w_wr   = w_dest_oh;
                w_data = w_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < 3; i++) r_rd_ptr[i] <= '0;
            r_g      <= 2'd0;
            r_last   <= 2'd2;
            r_grant  <= 3'b000;
            r_header <= '0;
            r_dest   <= 2'd0;
            r_cnt    <= 4'd0;
            r_drop   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        r_g     <= w_next;
                        r_last  <= w_next;
                        r_grant <= 3'b001 << w_next;
                        r_state <= S_HRD;
                    end
                end
                S_HRD: r_state <= S_HDEC;
                S_HDEC: begin
                    r_header      <= w_q;
                    r_dest        <= w_q[1:0];
                    r_cnt         <= w_q[11:8];
                    r_rd_ptr[r_g] <= r_rd_ptr[r_g] + 1'b1;
                    if (w_q[1:0] == 2'd0) begin
                        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                        r_state <= S_DROP;
                    end else begin
                        r_state <= S_HWR;
                    end
                end
                S_HWR: begin
                    if (!w_full) begin
                        if (r_cnt != 4'd0) begin
                            r_state <= S_PRD;
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= 3'b000;
                        end
                    end
                end
                S_PRD: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        r_grant <= 3'b000;
                    end else if (w_cur_pend && !w_full) begin
                        r_state <= S_PWR;
                    end
                end
                S_PWR: begin
                    r_rd_ptr[r_g] <= r_rd_ptr[r_g] + 1'b1;
                    r_cnt         <= r_cnt - 4'd1;
                    r_state       <= S_PRD;
                end
                S_DROP: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        r_grant <= 3'b000;
                    end else if (w_cur_pend) begin
                        r_rd_ptr[r_g] <= r_rd_ptr[r_g] + 1'b1;
                        r_cnt         <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 3'b000;
                end
            endcase
        end
    end

    assign ram_rden   = w_rden;
    assign fifo_wr    = w_wr;
    assign fifo_data  = w_data;
    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign drop_count = r_drop;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// tb/tb_switch_port_arbiter.sv - directed self-checking bench for switch_port_arbiter
module tb_switch_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [35:0] wr_ptr;
    logic [95:0] ram_q;
    logic [35:0] ram_rd_add;
    logic [2:0]  ram_rden;
    logic [2:0]  fifo_full;
    logic [31:0] fifo_data;
    logic [2:0]  fifo_wr;
    logic [2:0]  grant;
    logic        busy;
    logic [7:0]  drop_count;

    logic [31:0] mem [3][4096];
    logic [31:0] rq [3];
    logic [11:0] wp [3];
    logic [31:0] fq0[$];
    logic [31:0] fq1[$];
    logic [31:0] fq2[$];
    logic [2:0]  glog[$];
    logic [2:0]  prev_g = 3'b000;
    int          bad_out = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    switch_port_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_ptr(wr_ptr), .ram_q(ram_q),
        .ram_rd_add(ram_rd_add), .ram_rden(ram_rden), .fifo_full(fifo_full),
        .fifo_data(fifo_data), .fifo_wr(fifo_wr), .grant(grant), .busy(busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    assign ram_q = {rq[2], rq[1], rq[0]};

    always @(posedge clk) begin
        if (ram_rden[0]) rq[0] <= mem[0][ram_rd_add[11:0]];
        if (ram_rden[1]) rq[1] <= mem[1][ram_rd_add[23:12]];
        if (ram_rden[2]) rq[2] <= mem[2][ram_rd_add[35:24]];
    end

    always @(negedge clk) begin
        if (fifo_wr[0]) fq0.push_back(fifo_data);
        if (fifo_wr[1]) fq1.push_back(fifo_data);
        if (fifo_wr[2]) fq2.push_back(fifo_data);
        if (|(fifo_wr & fifo_full) || |(ram_rden & ~grant) || $countones(fifo_wr) > 1) bad_out++;
        if (grant != prev_g && grant != 3'b000) begin
            if (prev_g != 3'b000) bad_out++;
            glog.push_back(grant);
        end
        prev_g = grant;
    end

    task automatic put(input int p, input logic [31:0] w);
        mem[p][wp[p]] = w;
        wp[p] = wp[p] + 12'd1;
    endtask

    task automatic publish();
        wr_ptr = {wp[2], wp[1], wp[0]};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        fifo_full = 3'b000;
        for (int i = 0; i < 3; i++) wp[i] = 12'd0;
        publish();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        fq0.delete(); fq1.delete(); fq2.delete(); glog.delete();
        bad_out = 0;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy && ram_rd_add == wr_ptr) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %0h expected 0", grant); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        n_tests++; if ({fifo_wr, ram_rden} !== 6'd0) begin n_fail++; $display("FAIL reset_strobes: got %0h expected 0", {fifo_wr, ram_rden}); end
        n_tests++; if (fifo_data !== 32'd0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_data_drop: got %0h/%0h expected 0/0", fifo_data, drop_count); end
        n_tests++; if (ram_rd_add !== 36'd0) begin n_fail++; $display("FAIL reset_rd_add: got %0h expected 0", ram_rd_add); end
    endtask

    task automatic test_single_packet();
        logic [31:0] exp [4];
        bit to;
        exp = '{32'h0000_0302, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        do_reset();
        for (int i = 0; i < 4; i++) put(0, exp[i]);
        enable = 1'b1;
        publish();
        wait_idle(200, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected idle"); end
        n_tests++; if (fq1.size() != 4 || fq0.size() != 0 || fq2.size() != 0) begin n_fail++; $display("FAIL single_counts: got %0d/%0d/%0d expected 0/4/0", fq0.size(), fq1.size(), fq2.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (fq1[i] !== exp[i]) begin n_fail++; $display("FAIL single_word%0d: got %0h expected %0h", i, fq1[i], exp[i]); end
        end
        n_tests++; if (ram_rd_add[11:0] !== 12'd4) begin n_fail++; $display("FAIL single_rd_ptr: got %0d expected 4", ram_rd_add[11:0]); end
        n_tests++; if (glog.size() != 1 || glog[0] !== 3'b001) begin n_fail++; $display("FAIL single_grant: got %0d grants first %0h expected 1 grant 1", glog.size(), glog[0]); end
        n_tests++; if (bad_out != 0) begin n_fail++; $display("FAIL single_protocol: got %0d violations expected 0", bad_out); end
    endtask

    task automatic test_round_robin();
        logic [2:0] eg [3];
        bit to;
        eg = '{3'b001, 3'b010, 3'b100};
        do_reset();
        put(0, 32'h0000_1001); put(1, 32'h0000_2001); put(2, 32'h0000_3001);
        enable = 1'b1;
        publish();
        wait_idle(200, to);
        n_tests++; if (to || glog.size() != 3 || fq0.size() != 3) begin n_fail++; $display("FAIL rr1_counts: got to=%0d grants=%0d words=%0d expected 0/3/3", to, glog.size(), fq0.size()); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (glog[i] !== eg[i]) begin n_fail++; $display("FAIL rr1_grant%0d: got %0h expected %0h", i, glog[i], eg[i]); end
        end
        n_tests++; if (fq0[0] !== 32'h1001 || fq0[1] !== 32'h2001 || fq0[2] !== 32'h3001) begin n_fail++; $display("FAIL rr1_data: got %0h %0h %0h expected 1001 2001 3001", fq0[0], fq0[1], fq0[2]); end
        glog.delete(); fq0.delete();
        put(0, 32'h0000_4001); put(2, 32'h0000_5001);
        publish();
        wait_idle(200, to);
        n_tests++; if (to || glog.size() != 2 || glog[0] !== 3'b001 || glog[1] !== 3'b100) begin n_fail++; $display("FAIL rr2_grants: got n=%0d %0h %0h expected 1 4", glog.size(), glog[0], glog[1]); end
        n_tests++; if (fq0.size() != 2 || fq0[0] !== 32'h4001 || fq0[1] !== 32'h5001) begin n_fail++; $display("FAIL rr2_data: got n=%0d %0h %0h expected 4001 5001", fq0.size(), fq0[0], fq0[1]); end
    endtask

    task automatic test_full_stall();
        logic [31:0] exp [5];
        int n;
        int viol;
        bit to;
        exp = '{32'h0000_0401, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
        do_reset();
        for (int i = 0; i < 5; i++) put(0, exp[i]);
        enable = 1'b1;
        publish();
        n = 0;
        for (int c = 0; c < 50 && n < 2; c++) begin
            @(negedge clk);
            if (fifo_wr[0]) n++;
        end
        n_tests++; if (n != 2) begin n_fail++; $display("FAIL stall_start: got %0d writes expected 2", n); end
        @(posedge clk);
        #1 fifo_full[0] = 1'b1;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (ram_rden != 3'b000 || fifo_wr != 3'b000) viol++;
        end
        @(posedge clk);
        #1 fifo_full[0] = 1'b0;
        wait_idle(200, to);
        n_tests++; if (viol != 0) begin n_fail++; $display("FAIL stall_quiet: got %0d active cycles expected 0", viol); end
        n_tests++; if (to || fq0.size() != 5) begin n_fail++; $display("FAIL stall_count: got to=%0d n=%0d expected 0/5", to, fq0.size()); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (fq0[i] !== exp[i]) begin n_fail++; $display("FAIL stall_word%0d: got %0h expected %0h", i, fq0[i], exp[i]); end
        end
        n_tests++; if (bad_out != 0) begin n_fail++; $display("FAIL stall_protocol: got %0d violations expected 0", bad_out); end
    endtask

    task automatic test_drop();
        bit to;
        do_reset();
        put(1, 32'h0000_0500);
        for (int i = 0; i < 5; i++) put(1, 32'hDEAD_0000 + i);
        enable = 1'b1;
        publish();
        wait_idle(200, to);
        n_tests++; if (to || ram_rd_add[23:12] !== 12'd6) begin n_fail++; $display("FAIL drop_rd_ptr: got to=%0d ptr=%0d expected 0/6", to, ram_rd_add[23:12]); end
        n_tests++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_count: got %0d expected 1", drop_count); end
        n_tests++; if (fq0.size() + fq1.size() + fq2.size() != 0) begin n_fail++; $display("FAIL drop_writes: got %0d expected 0", fq0.size() + fq1.size() + fq2.size()); end
        put(1, 32'h0000_0103); put(1, 32'hD00D_0001);
        publish();
        wait_idle(200, to);
        n_tests++; if (to || fq2.size() != 2 || fq2[0] !== 32'h0103 || fq2[1] !== 32'hD00D_0001) begin n_fail++; $display("FAIL drop_next: got n=%0d %0h %0h expected 103 d00d0001", fq2.size(), fq2[0], fq2[1]); end
        n_tests++; if (ram_rd_add[23:12] !== 12'd8) begin n_fail++; $display("FAIL drop_next_ptr: got %0d expected 8", ram_rd_add[23:12]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        bit to;
        exp = '{32'h0000_0301, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
        do_reset();
        for (int k = 0; k < 255; k++) begin
            put(2, 32'h0000_0F00);
            for (int j = 0; j < 15; j++) put(2, 32'h0);
        end
        put(2, 32'h0000_0D00);
        for (int j = 0; j < 13; j++) put(2, 32'h0);
        enable = 1'b1;
        publish();
        wait_idle(8000, to);
        n_tests++; if (to || ram_rd_add[35:24] !== 12'd4094) begin n_fail++; $display("FAIL wrap_pre_ptr: got to=%0d ptr=%0d expected 0/4094", to, ram_rd_add[35:24]); end
        n_tests++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_saturate: got %0d expected 255", drop_count); end
        for (int i = 0; i < 4; i++) put(2, exp[i]);
        publish();
        wait_idle(200, to);
        n_tests++; if (to || fq0.size() != 4) begin n_fail++; $display("FAIL wrap_count: got to=%0d n=%0d expected 0/4", to, fq0.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (fq0[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_word%0d: got %0h expected %0h", i, fq0[i], exp[i]); end
        end
        n_tests++; if (ram_rd_add[35:24] !== 12'd2) begin n_fail++; $display("FAIL wrap_end_ptr: got %0d expected 2", ram_rd_add[35:24]); end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        bit to;
        do_reset();
        put(1, 32'h0000_0000);
        enable = 1'b1;
        publish();
        wait_idle(200, to);
        n_tests++; if (to || drop_count !== 8'd1) begin n_fail++; $display("FAIL rst_pre_drop: got to=%0d count=%0d expected 0/1", to, drop_count); end
        put(0, 32'h0000_0402);
        for (int i = 0; i < 4; i++) put(0, 32'h5555_0000 + i);
        publish();
        n = 0;
        for (int c = 0; c < 50 && n < 2; c++) begin
            @(negedge clk);
            if (fifo_wr[1]) n++;
        end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (n != 2 || {fifo_wr, ram_rden, grant, busy} !== 10'd0 || fifo_data !== 32'd0) begin n_fail++; $display("FAIL rst_async_outputs: got n=%0d ctl=%0h data=%0h expected 2/0/0", n, {fifo_wr, ram_rden, grant, busy}, fifo_data); end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) wp[i] = 12'd0;
        publish();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_tests++; if (ram_rd_add !== 36'd0 || drop_count !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_state: got ptrs=%0h drop=%0d busy=%0d expected 0/0/0", ram_rd_add, drop_count, busy); end
        glog.delete(); fq0.delete();
        put(1, 32'h0000_1001); put(0, 32'h0000_2001);
        enable = 1'b1;
        publish();
        wait_idle(200, to);
        n_tests++; if (to || glog.size() != 2 || glog[0] !== 3'b001 || glog[1] !== 3'b010) begin n_fail++; $display("FAIL rst_first_grant: got n=%0d %0h %0h expected 1 2", glog.size(), glog[0], glog[1]); end
        n_tests++; if (fq0.size() != 2 || fq0[0] !== 32'h2001 || fq0[1] !== 32'h1001) begin n_fail++; $display("FAIL rst_data: got n=%0d %0h %0h expected 2001 1001", fq0.size(), fq0[0], fq0[1]); end
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        fifo_full = 3'b000;
        wr_ptr = '0;
        for (int i = 0; i < 3; i++) begin
            rq[i] = 32'd0;
            wp[i] = 12'd0;
        end
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_drop();
        test_wrap();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_port_arbiter.md
Name: switch_port_arbiter

Overview:
Round-robin arbiter that moves whole packets from the three input RAMs into the three per-destination output FIFOs. It owns the input-RAM read side (read addresses and read enables) and the FIFO write side (data and write strobes). It decodes each packet header to find the destination, then streams header plus payload into the destination FIFO. Throttling comes from FIFO full and input-RAM occupancy.

Parameters:
ADDR_W, 12, input-RAM address width (pointers wrap modulo 2^ADDR_W)
DATA_W, 32, word width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = new grants allowed; 0 = finish current packet then hold in IDLE
wr_ptr  in  3*ADDR_W  input-RAM write pointers; port i (i = 0..2 for ports 1..3) at [ADDR_W*i +: ADDR_W]
ram_q  in  3*DATA_W  input-RAM read data, port i at [DATA_W*i +: DATA_W]; valid 1 cycle after rden
ram_rd_add  out  3*ADDR_W  input-RAM read addresses (equal to each port's rd_ptr)
ram_rden  out  3  input-RAM read enables, one per port
fifo_full  in  3  output-FIFO full flags
fifo_data  out  DATA_W  write data, shared by all three FIFOs
fifo_wr  out  3  output-FIFO write strobes, at most one high
grant  out  3  one-hot, current input port owner; 0 when idle
busy  out  1  high whenever state != IDLE
drop_count  out  8  packets discarded (dest = 0), saturates at 255

Behaviour:
- Header word: [1:0] = destination (1..3 selects FIFO 1..3; 0 = drop); [11:8] = payload length L (0..15). Packet = header + L payload words, contiguous in the RAM.
- Per-port rd_ptr[i]. Port i is pending when rd_ptr[i] != wr_ptr[i].
- Reset (asynchronous, any state):
  - state = IDLE; all rd_ptr = 0; last grant = port 3, so port 1 wins first.
  - grant, fifo_wr, ram_rden = 0; fifo_data = 0; drop_count = 0.
  - An in-flight packet is abandoned; there is no partial recovery.
- FSM states:
  - IDLE: if enable and any port pending, grant the first pending port searching cyclically from (last+1). Latch grant and last, go to HRD. If nothing is pending, stay in IDLE.
  - HRD: rden[g] = 1 at rd_ptr[g] -> HDEC.
  - HDEC: q valid. Latch header, dest, cnt = L; rd_ptr[g] += 1.
    - dest = 0: drop_count += 1 (saturating), skip = L -> DROP.
    - dest != 0: -> HWR.
  - HWR: if fifo_full[dest-1] = 0, fifo_wr[dest-1] = 1, fifo_data = header; then go to PRD if cnt != 0, else IDLE. Otherwise stall.
  - PRD: if cnt = 0 -> IDLE. Else, if port pending and fifo_full[dest-1] = 0, rden[g] = 1 -> PWR. Otherwise stall with no rden.
  - PWR: fifo_wr[dest-1] = 1, fifo_data = ram_q[g]; rd_ptr[g] += 1; cnt -= 1 -> PRD.
  - DROP: while skip != 0 and port pending, rd_ptr[g] += 1 and skip -= 1, one word per cycle. When skip = 0 -> IDLE.
- Throughput:
  - One payload word per 2 cycles (PRD/PWR alternation). This guarantees full is re-sampled before every write, so a FIFO is never written while full.
  - Header-to-header minimum is 4 cycles for L = 0.
- Output validity:
  - fifo_wr is never asserted in the same cycle that its full flag is high.
  - ram_rden is asserted only for the granted port.
- Grant lifetime: grant stays stable from IDLE exit until return to IDLE. Packets are never interleaved on the input side or on the output side.
- enable deasserted mid-packet: the packet completes; the FSM then waits in IDLE.
- Pointer arithmetic is modulo 2^ADDR_W. Wrap from 4095 to 0 is seamless, including inside a packet.
- An empty input RAM mid-packet (writer slower than reader) stalls in PRD or DROP; the arbiter never reads past wr_ptr.
- grant clears to 0 on entering IDLE. busy = (state != IDLE).

Test Plan:
- Port 1 holds header 0x0000_0302 + 3 payload words (A, B, C) -> FIFO 2 receives 0x302, A, B, C. fifo_wr = 3'b010 four times. rd_ptr1 = 4. grant = 3'b001 throughout.
- Ports 1, 2 and 3 each hold a 1-word packet (L = 0) to dest 1 at the same time -> grant order 1, 2, 3. Then fresh packets on ports 1 and 3 -> grant order 1, 3.
- fifo_full[0] forced high for 10 cycles during a 4-word payload -> no fifo_wr[0] and no rden during the stall. All 5 words arrive in order with none lost or duplicated.
- Header dest = 0, L = 5 on port 2 -> no fifo_wr asserted. rd_ptr2 advances by 6. drop_count = 1. The next packet on port 2 is forwarded normally.
- Packet header at address 4094 with L = 3 -> words are read from 4094, 4095, 0, 1 and delivered intact. rd_ptr ends at 2.
- reset pulsed low during PWR -> outputs are 0 in the same cycle. After release: state IDLE, all rd_ptr = 0, drop_count = 0, and the first grant goes to port 1.
